softmax_normalizer: RTL
=======================

// Module: softmax_normalizer
// PURPOSE
//  Downstream stage of the exp approximation unit. Accepts one vector of exp codes {pos[4:0], mant[15:0]},
//  buffers them and accumulates their linear sum. It then emits each element's softmax probability
//  exp_i/sum as an unsigned Q0.16 fraction, in input order, on a valid/ready stream.
// PARAMETERS
//  VEC_LEN  8   maximum elements per vector; buffer depth (>=2, power of 2)
//  DIV_CYC  17  quotient bits produced by the serial divider; fixed at 17, not user-tunable
// PORTS
//  clk       in   1   single clock; all state updates on rising edge
//  rst_n     in   1   asynchronous, active-low reset
//  in_valid  in   1   in_exp/in_last valid
//  in_ready  out  1   block can accept an element
//  in_exp    in   21  exp code: [20:16]=pos, [15:0]=mant
//  in_last   in   1   final element of the vector
//  out_valid out  1   out_prob/out_last valid
//  out_ready in   1   downstream accepts output
//  out_prob  out  16  probability, Q0.16, saturated to 16'hFFFF
//  out_last  out  1   marks the final probability of the vector
// BEHAVIOUR
//  Reset values: in_ready=1, out_valid=0, out_prob=0, out_last=0, state=ACCUM, count=0, sum=0, idx=0.
//  Decode: posc = min(pos,16); L = {16'b0,mant} << posc (32 bit unsigned). Accumulator width ACC_W = 32+$clog2(VEC_LEN).
//  FSM ACCUM -> DIVIDE -> OUTPUT -> (DIVIDE | ACCUM).
//  ACCUM:
//   - in_ready=1.
//   - On in_valid&&in_ready: buf[count]<=L; sum<=sum+L; count++.
//   - The element is last if in_last=1 or count==VEC_LEN-1 (forced end; any in_last beyond that is ignored).
//   - After accepting the last element: in_ready<=0, idx<=0, go to DIVIDE.
//  DIVIDE:
//   - Start the divider on buf[idx] and sum.
//   - Dividend = buf[idx]<<16; divisor = sum.
//   - Restoring division produces 1 quotient bit per cycle, DIV_CYC cycles.
//   - When done: q17 = quotient; out_prob <= (q17>=2^16) ? 16'hFFFF : q17[15:0].
//   - sum==0: divider bypassed, out_prob<=0; result is still presented after DIV_CYC cycles.
//   - Set out_last <= (idx==count-1) and out_valid<=1, then go to OUTPUT.
//  OUTPUT:
//   - out_valid, out_prob and out_last hold stable until out_ready.
//   - On handshake: out_valid<=0.
//   - If out_last: count<=0, sum<=0, in_ready<=1, go to ACCUM; else idx++ and go to DIVIDE.
//  Latency: out_valid rises DIV_CYC+1 cycles after the last-element accept or after the previous output handshake.
//   - Zero-stall throughput: one probability per DIV_CYC+2 cycles.
//  Rules:
//   - No input is accepted while DIVIDE/OUTPUT are active; one vector in flight at a time.
//   - out_valid never drops without a handshake.
//   - in_last on the first element gives a single-element vector; the output is 16'hFFFF with out_last=1.
//   - Reset mid-operation aborts the vector with no partial output: all registers return to reset values
//     and the next vector is processed normally.
//   - A sum of VEC_LEN x 0xFFFF0000 cannot overflow ACC_W.
// STRUCTURE
//  softmax_pkg:
//   - localparams EXP_W=21, MANT_W=16, POS_W=5, POS_MAX=16, PROB_W=16, LIN_W=32.
//   - typedef enum {ACCUM, DIVIDE, OUTPUT} norm_state_t.
//   - Function exp_to_lin(pos,mant).
//  Sub-module softmax_div_serial: restoring divider with start/busy/done, registered quotient, parameterised by ACC_W.
//  Top level: FSM, buffer, accumulator, output register.
// TESTING
//  1. Four elements {16,0x1000}, last on the 4th -> sum=0x40000000; out_prob 0x4000 x4; out_last only on the 4th.
//  2. Two elements {16,0x8000},{15,0x8000} -> out_prob 0xAAAA, then 0x5555; out_last on the second.
//  3. Single element {10,0x1234}, in_last=1 -> out_prob 0xFFFF, out_last=1; in_ready returns to 1 after the handshake.
//  4. Eight elements with mant=0, no in_last -> the 8th is forced last; eight outputs 0x0000, out_last on the 8th.
//  5. Out_ready held low for 10 cycles during OUTPUT -> out_valid, out_prob, out_last stable; in_ready stays 0.
//  6. rst_n pulsed low mid-DIVIDE -> out_valid=0 and in_ready=1 immediately; a following vector per test 2 gives 0xAAAA/0x5555.
//  Also: pos=20 with mant=0x0001 behaves identically to pos=16 (clamp).

Source files
------------

// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax normalizer.
// Holds the exp-code field widths, the normalizer FSM state type and the helper that turns an
// exp code {pos, mant} into its 32-bit linear value.
package softmax_pkg;

  localparam int unsigned EXP_W   = 21;
  localparam int unsigned MANT_W  = 16;
  localparam int unsigned POS_W   = 5;
  localparam int unsigned POS_MAX = 16;
  localparam int unsigned PROB_W  = 16;
  localparam int unsigned LIN_W   = 32;

  typedef enum logic [1:0] {
    ACCUM,
    DIVIDE,
    OUTPUT
  } norm_state_t;

  // Shift counts above POS_MAX clamp so the mantissa never leaves the 32-bit linear word.
  function automatic logic [LIN_W-1:0] exp_to_lin(input logic [POS_W-1:0]  pos,
                                                  input logic [MANT_W-1:0] mant);
    logic [POS_W-1:0] posc;
    posc = (pos > POS_W'(POS_MAX)) ? POS_W'(POS_MAX) : pos;
    return LIN_W'(mant) << posc;
  endfunction

endpackage

// File: rtl/softmax_div_serial.sv
// Restoring serial divider producing QUOT_W quotient bits of (num_i << (QUOT_W-1)) / den_i.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start_i       : load operands and perform the first step (ignored while busy)
//   num_i, den_i  : numerator (pre-shift) and divisor, ACC_W bits each
//   busy_o        : division in progress (stays high through the done cycle)
//   done_o        : quot_o holds the final quotient this cycle
//   quot_o        : registered quotient
// Precondition: num_i <= den_i, so the quotient fits QUOT_W bits and the initial partial
// remainder (num_i >> 1) is already below the divisor.
module softmax_div_serial #(
  parameter int unsigned ACC_W  = 35,
  parameter int unsigned QUOT_W = 17
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ACC_W-1:0]  num_i,
  input  logic [ACC_W-1:0]  den_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [QUOT_W-1:0] quot_o
);

  localparam int unsigned CNT_W = $clog2(QUOT_W + 1);

  logic [ACC_W-1:0]  rem_q, rem_d;
  logic [ACC_W-1:0]  den_q, den_d;
  logic [QUOT_W-1:0] quot_q, quot_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;

  logic             load;
  logic [ACC_W-1:0] step_rem;
  logic             step_bit;
  logic [ACC_W-1:0] step_den;
  logic [ACC_W:0]   trial;
  logic [ACC_W:0]   diff;
  logic             ge;
  logic [ACC_W-1:0] rem_next;

  always_comb begin
    load     = start_i && !busy_q;
    // The dividend is num << (QUOT_W-1): the first step consumes num[0], all later bits are zero.
    step_rem = load ? (num_i >> 1) : rem_q;
    step_bit = load ? num_i[0] : 1'b0;
    step_den = load ? den_i : den_q;
    trial    = {step_rem, step_bit};
    diff     = trial - {1'b0, step_den};
    ge       = (trial >= {1'b0, step_den});
    rem_next = ge ? diff[ACC_W-1:0] : trial[ACC_W-1:0];
  end

  always_comb begin
    rem_d  = rem_q;
    den_d  = den_q;
    quot_d = quot_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (load) begin
      rem_d  = rem_next;
      den_d  = den_i;
      quot_d = {{(QUOT_W-1){1'b0}}, ge};
      cnt_d  = CNT_W'(QUOT_W - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        rem_d  = rem_next;
        quot_d = {quot_q[QUOT_W-2:0], ge};
        cnt_d  = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q  <= '0;
      den_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      den_q  <= den_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == '0);
  assign quot_o = quot_q;

endmodule

// File: rtl/softmax_normalizer.sv
// Softmax normalizer: buffers one vector of exp codes, accumulates their linear sum, then emits
// exp_i/sum for each element as a saturated Q0.16 fraction, in input order.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake; in_exp = {pos[4:0], mant[15:0]}, in_last ends vector
//   out_valid/out_ready : output handshake; out_prob Q0.16, out_last marks the final element
module softmax_normalizer
  import softmax_pkg::*;
#(
  parameter int unsigned VEC_LEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROB_W-1:0] out_prob,
  output logic              out_last
);

  localparam int unsigned DIV_CYC = 17;
  localparam int unsigned IDX_W   = $clog2(VEC_LEN);
  localparam int unsigned CNT_W   = IDX_W + 1;
  localparam int unsigned ACC_W   = LIN_W + IDX_W;

  norm_state_t       state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ACC_W-1:0]  sum_q, sum_d;
  logic [LIN_W-1:0]  buf_q [VEC_LEN];
  logic [LIN_W-1:0]  buf_d [VEC_LEN];
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [PROB_W-1:0] out_prob_q, out_prob_d;
  logic              out_last_q, out_last_d;

  logic [LIN_W-1:0]   lin;
  logic               div_start;
  logic               div_busy;
  logic               div_done;
  logic [DIV_CYC-1:0] div_quot;

  softmax_div_serial #(
    .ACC_W  (ACC_W),
    .QUOT_W (DIV_CYC)
  ) u_div (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (div_start),
    .num_i   (ACC_W'(buf_q[idx_q])),
    .den_i   (sum_q),
    .busy_o  (div_busy),
    .done_o  (div_done),
    .quot_o  (div_quot)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM: begin
        if (in_valid && in_ready_q &&
            (in_last || count_q == CNT_W'(VEC_LEN - 1))) begin
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        if (div_done) state_d = OUTPUT;
      end
      OUTPUT: begin
        if (out_ready) state_d = out_last_q ? ACCUM : DIVIDE;
      end
      default: state_d = ACCUM;
    endcase
  end

  // Datapath and output register updates
  always_comb begin
    count_d     = count_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    buf_d       = buf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_prob_d  = out_prob_q;
    out_last_d  = out_last_q;
    div_start   = 1'b0;
    lin         = exp_to_lin(in_exp[EXP_W-1:MANT_W], in_exp[MANT_W-1:0]);
    unique case (state_q)
      ACCUM: begin
        if (in_valid && in_ready_q) begin
          buf_d[count_q[IDX_W-1:0]] = lin;
          sum_d   = sum_q + ACC_W'(lin);
          count_d = count_q + CNT_W'(1);
          // A full buffer ends the vector even without in_last.
          if (in_last || count_q == CNT_W'(VEC_LEN - 1)) begin
            in_ready_d = 1'b0;
            idx_d      = '0;
          end
        end
      end
      DIVIDE: begin
        div_start = !div_busy;
        if (div_done) begin
          // Zero sum: the divider still runs for timing, its result is discarded.
          if (sum_q == '0) begin
            out_prob_d = '0;
          end else if (div_quot[DIV_CYC-1]) begin
            out_prob_d = '1;
          end else begin
            out_prob_d = div_quot[PROB_W-1:0];
          end
          out_last_d  = ({1'b0, idx_q} == (count_q - CNT_W'(1)));
          out_valid_d = 1'b1;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            count_d    = '0;
            sum_d      = '0;
            in_ready_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_prob_q  <= '0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < int'(VEC_LEN); i++) buf_q[i] <= '0;
    end else begin
      count_q     <= count_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_prob_q  <= out_prob_d;
      out_last_q  <= out_last_d;
      buf_q       <= buf_d;
    end
  end

  // Outputs
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_prob  = out_prob_q;
  assign out_last  = out_last_q;

endmodule
